// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the five-stage pipeline: mem stall > mul/div > load-use > branch flush.
// Optional stall performance counter enabled by defining PIPE_STALL_PERF_EN.
module pipeline_stall_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6,
  parameter int MEM_TIMEOUT   = 255,
  parameter int PERF_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use_req,
  input  logic              branch_taken,
  input  logic              muldiv_start,
  input  logic              mem_busy,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_exe_hold,
  output logic              id_exe_bubble,
  output logic              exe_mem_hold,
  output logic              exe_mem_bubble,
  output logic              mem_wb_bubble,
  output logic              muldiv_done,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] perf_stall_cycles
);

  typedef enum logic {IDLE, MULDIV} state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              mem_timeout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pc_hold        = 1'b0;
    if_id_hold     = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_hold    = 1'b0;
    id_exe_bubble  = 1'b0;
    exe_mem_hold   = 1'b0;
    exe_mem_bubble = 1'b0;
    mem_wb_bubble  = 1'b0;
    muldiv_done    = 1'b0;
    if (rst) begin
      state_next = IDLE;
    end else if (mem_busy) begin
      // Whole front end freezes while MEM drains a NOP into WB.
      pc_hold       = 1'b1;
      if_id_hold    = 1'b1;
      id_exe_hold   = 1'b1;
      exe_mem_hold  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (muldiv_start) begin
            pc_hold        = 1'b1;
            if_id_hold     = 1'b1;
            id_exe_hold    = 1'b1;
            exe_mem_bubble = 1'b1;
            cnt_next       = CNT_LOAD;
            state_next     = MULDIV;
          end else if (load_use_req) begin
            pc_hold       = 1'b1;
            if_id_hold    = 1'b1;
            id_exe_bubble = 1'b1;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        MULDIV: begin
          if (cnt_reg != '0) begin
            pc_hold        = 1'b1;
            if_id_hold     = 1'b1;
            id_exe_hold    = 1'b1;
            exe_mem_bubble = 1'b1;
            cnt_next       = cnt_reg - 1'b1;
          end else begin
            muldiv_done = 1'b1;
            state_next  = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Consecutive-busy counter saturates so the sticky flag cannot be re-armed by wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else if (mem_busy) begin
      if (wait_cnt_reg != WAIT_MAX) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      if (wait_cnt_reg == WAIT_LAST) mem_timeout_reg <= 1'b1;
    end else begin
      wait_cnt_reg <= '0;
    end
  end

  assign mem_timeout = mem_timeout_reg;

`ifdef PIPE_STALL_PERF_EN
  logic [PERF_W-1:0] perf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_reg <= '0;
    end else if (pc_hold && (perf_reg != {PERF_W{1'b1}})) begin
      perf_reg <= perf_reg + 1'b1;
    end
  end

  assign perf_stall_cycles = perf_reg;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed literal checks plus randomized run against a behavioural model.
module tb_pipeline_stall_ctrl;
  localparam int N  = 4;
  localparam int T  = 3;
  localparam int PW = 8;
  localparam int PMAX = (1 << PW) - 1;

  // Control vector: {pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_bubble,
  //                  exe_mem_hold, exe_mem_bubble, mem_wb_bubble, muldiv_done}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_LU   = 9'b110010000;
  localparam logic [8:0] C_BR   = 9'b001000000;
  localparam logic [8:0] C_MD   = 9'b110100100;
  localparam logic [8:0] C_MEM  = 9'b110101010;
  localparam logic [8:0] C_DONE = 9'b000000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_use_req = 1'b0, branch_taken = 1'b0, muldiv_start = 1'b0, mem_busy = 1'b0;
  logic pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_bubble;
  logic exe_mem_hold, exe_mem_bubble, mem_wb_bubble, muldiv_done, mem_timeout;
  logic [PW-1:0] perf_stall_cycles;
  logic [8:0] ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .MULDIV_CYCLES(N), .CNT_W(3), .MEM_TIMEOUT(T), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .load_use_req(load_use_req), .branch_taken(branch_taken),
    .muldiv_start(muldiv_start), .mem_busy(mem_busy),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_exe_hold(id_exe_hold), .id_exe_bubble(id_exe_bubble),
    .exe_mem_hold(exe_mem_hold), .exe_mem_bubble(exe_mem_bubble),
    .mem_wb_bubble(mem_wb_bubble), .muldiv_done(muldiv_done),
    .mem_timeout(mem_timeout), .perf_stall_cycles(perf_stall_cycles)
  );

  assign ctl = {pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_bubble,
                exe_mem_hold, exe_mem_bubble, mem_wb_bubble, muldiv_done};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mul/div tracked as cycles elapsed since start, mem as run length.
  bit md_active = 1'b0;
  int md_elapsed = 0;
  int mem_run = 0;
  bit to_sticky = 1'b0;
  int perf_m = 0;
  logic [8:0] exp_ctl;

  always @(negedge clk) begin
    if (rst) begin
      exp_ctl = C_NONE;
      md_active = 1'b0; md_elapsed = 0; mem_run = 0; to_sticky = 1'b0; perf_m = 0;
    end else if (mem_busy)                   exp_ctl = C_MEM;
    else if (md_active)                      exp_ctl = (md_elapsed == N) ? C_DONE : C_MD;
    else if (muldiv_start)                   exp_ctl = C_MD;
    else if (load_use_req)                   exp_ctl = C_LU;
    else if (branch_taken)                   exp_ctl = C_BR;
    else                                     exp_ctl = C_NONE;

    chk("model_ctl", 32'(ctl), 32'(exp_ctl));
    chk("model_timeout", 32'(mem_timeout), 32'(to_sticky));
`ifdef PIPE_STALL_PERF_EN
    chk("model_perf", 32'(perf_stall_cycles), 32'(perf_m));
`else
    chk("model_perf", 32'(perf_stall_cycles), 32'd0);
`endif

    if (!rst) begin
      if (!mem_busy) begin
        if (md_active) begin
          if (md_elapsed == N) md_active = 1'b0;
          else md_elapsed++;
        end else if (muldiv_start) begin
          md_active = 1'b1;
          md_elapsed = 1;
        end
        mem_run = 0;
      end else begin
        mem_run++;
        if (mem_run >= T) to_sticky = 1'b1;
      end
      if (exp_ctl[8] && perf_m < PMAX) perf_m++;
    end
  end

  task automatic cyc(input logic lu, input logic br, input logic ms, input logic mb);
    @(posedge clk); #1;
    load_use_req = lu; branch_taken = br; muldiv_start = ms; mem_busy = mb;
    @(negedge clk); #1;
    $display("txn t=%0t lu=%b br=%b ms=%b mb=%b ctl=%b to=%b perf=%0d",
             $time, lu, br, ms, mb, ctl, mem_timeout, perf_stall_cycles);
  endtask

  initial begin
    int burst;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", 32'(ctl), 32'(C_NONE));
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    chk("reset_perf", 32'(perf_stall_cycles), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    cyc(1, 0, 0, 0); chk("lu_one", 32'(ctl), 32'(C_LU));
    cyc(0, 0, 0, 0); chk("lu_after", 32'(ctl), 32'(C_NONE));
    cyc(1, 1, 0, 0); chk("lu_beats_br", 32'(ctl), 32'(C_LU));
    cyc(0, 1, 0, 0); chk("br_flush", 32'(ctl), 32'(C_BR));

    cyc(0, 0, 1, 0); chk("md_c0", 32'(ctl), 32'(C_MD));
    cyc(1, 1, 1, 0); chk("md_c1_ignore", 32'(ctl), 32'(C_MD));
    cyc(0, 0, 0, 0); chk("md_c2", 32'(ctl), 32'(C_MD));
    cyc(0, 0, 0, 0); chk("md_c3", 32'(ctl), 32'(C_MD));
    cyc(0, 0, 0, 0); chk("md_c4_done", 32'(ctl), 32'(C_DONE));
    cyc(0, 0, 0, 0); chk("md_c5_idle", 32'(ctl), 32'(C_NONE));

    cyc(0, 0, 1, 0); chk("mdm_c0", 32'(ctl), 32'(C_MD));
    cyc(0, 0, 0, 0); chk("mdm_c1", 32'(ctl), 32'(C_MD));
    cyc(0, 0, 0, 1); chk("mdm_c2_mem", 32'(ctl), 32'(C_MEM));
    cyc(0, 0, 0, 0); chk("mdm_c3", 32'(ctl), 32'(C_MD));
    cyc(0, 0, 0, 0); chk("mdm_c4", 32'(ctl), 32'(C_MD));
    cyc(0, 0, 0, 0); chk("mdm_c5_done", 32'(ctl), 32'(C_DONE));

    cyc(0, 0, 0, 1); chk("to_b1", 32'(mem_timeout), 32'd0);
    cyc(0, 0, 0, 1); chk("to_b2", 32'(mem_timeout), 32'd0);
    cyc(1, 1, 1, 1); chk("to_b3", 32'(mem_timeout), 32'd0);
    chk("to_b3_ctl", 32'(ctl), 32'(C_MEM));
    cyc(0, 0, 0, 0); chk("to_set", 32'(mem_timeout), 32'd1);
    cyc(0, 0, 0, 0); chk("to_sticky", 32'(mem_timeout), 32'd1);
`ifdef PIPE_STALL_PERF_EN
    chk("perf_held", 32'(perf_stall_cycles), 32'd14);
`endif

    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rst_mid_ctl", 32'(ctl), 32'(C_NONE));
    chk("rst_mid_to", 32'(mem_timeout), 32'd0);
    chk("rst_mid_perf", 32'(perf_stall_cycles), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0); chk("rst_no_done", 32'(ctl), 32'(C_NONE));
    end

    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 6);
      mem_busy     = (burst > 0);
      if (burst > 0) burst--;
      load_use_req = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      muldiv_start = ($urandom_range(0, 7) == 0);
      rst          = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; load_use_req = 0; branch_taken = 0; muldiv_start = 0; mem_busy = 0;
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
